// File: rtl/tag_ct_coalescer_pkg.sv
// ============================================================================
// Module  : tag_ct_coalescer_pkg
// Brief   : Shared widths, count limit and tag/count word type for the
//           coalescer and the BD tag merge stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tag_ct_coalescer_pkg;

  localparam int NTAG_DEFAULT     = 11;
  localparam int NCT_DEFAULT      = 9;
  localparam int NTIMEOUT_DEFAULT = 64;
  localparam int CT_MAX           = (1 << NCT_DEFAULT) - 1;

  typedef struct packed {
    logic [NTAG_DEFAULT-1:0] tag;
    logic [NCT_DEFAULT-1:0]  ct;
  } tag_ct_t;

  // True when a + b still fits the count field (checked one bit wider).
  function automatic logic ct_sum_fits(input logic [NCT_DEFAULT-1:0] a,
                                       input logic [NCT_DEFAULT-1:0] b);
    logic [NCT_DEFAULT:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s <= NCT_DEFAULT'(CT_MAX));
  endfunction

endpackage

`default_nettype wire

// File: rtl/tag_ct_flush_timer.sv
// ============================================================================
// Module  : tag_ct_flush_timer
// Brief   : Idle counter for a held word; pulses timeout after Ntimeout idle
//           cycles. Built only with TAG_CT_COALESCER_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef TAG_CT_COALESCER_TIMEOUT_EN
module tag_ct_flush_timer #(
  parameter int Ntimeout = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic hold_v,
  input  logic accept,
  input  logic flush,
  output logic timeout
);

  localparam int             c_w     = $clog2(Ntimeout + 1);
  localparam logic [c_w-1:0] c_limit = c_w'(Ntimeout);

  logic [c_w-1:0] idle_q;
  logic [c_w-1:0] idle_d;

  // Counter parks at the limit while the output register is busy.
  always_comb begin
    idle_d = idle_q;
    if (accept || flush || !hold_v) begin
      idle_d = '0;
    end else if (idle_q != c_limit) begin
      idle_d = idle_q + c_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign timeout = hold_v && (idle_q == c_limit);

endmodule
`endif

`default_nettype wire

// File: rtl/tag_ct_coalescer.sv
// ============================================================================
// Module  : tag_ct_coalescer
// Brief   : Merges consecutive same-tag counts into one hold word and hands
//           finished words to a registered output. Optional idle-timeout
//           flush under macro TAG_CT_COALESCER_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_ct_coalescer
  import tag_ct_coalescer_pkg::*;
#(
  parameter int Ntag     = NTAG_DEFAULT,
  parameter int Nct      = NCT_DEFAULT,
  parameter int Ntimeout = NTIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tag_ct_in_v,
  output logic            tag_ct_in_a,
  input  logic [Ntag-1:0] tag_ct_in_tag,
  input  logic [Nct-1:0]  tag_ct_in_ct,
  output logic            tag_ct_out_v,
  input  logic            tag_ct_out_a,
  output logic [Ntag-1:0] tag_ct_out_tag,
  output logic [Nct-1:0]  tag_ct_out_ct
);

  localparam logic [Nct-1:0] c_ct_max = '1;

  logic            hold_v_q,   hold_v_d;
  logic [Ntag-1:0] hold_tag_q, hold_tag_d;
  logic [Nct-1:0]  hold_ct_q,  hold_ct_d;
  logic            out_v_q,    out_v_d;
  logic [Ntag-1:0] out_tag_q,  out_tag_d;
  logic [Nct-1:0]  out_ct_q,   out_ct_d;

  logic [Nct:0]    w_sum;
  logic            w_merge_ok;
  logic            w_accept;
  logic            w_out_free;
  logic            w_flush;
  logic            w_timeout;

  always_comb begin
    w_sum      = {1'b0, hold_ct_q} + {1'b0, tag_ct_in_ct};
    w_merge_ok = hold_v_q && (tag_ct_in_tag == hold_tag_q) && (w_sum <= {1'b0, c_ct_max});
  end

  // Ready depends only on registered state and the offered word, never on out.a.
  assign tag_ct_in_a = !reset && (!hold_v_q || w_merge_ok || !out_v_q);
  assign w_accept    = tag_ct_in_v && tag_ct_in_a;
  assign w_out_free  = !out_v_q || tag_ct_out_a;
  assign w_flush     = hold_v_q && !w_accept && w_out_free &&
                       ((hold_ct_q == c_ct_max) || w_timeout);

`ifdef TAG_CT_COALESCER_TIMEOUT_EN
  tag_ct_flush_timer #(
    .Ntimeout (Ntimeout)
  ) u_flush_timer (
    .clk     (clk),
    .reset   (reset),
    .hold_v  (hold_v_q),
    .accept  (w_accept),
    .flush   (w_flush),
    .timeout (w_timeout)
  );
`else
  localparam int c_unused_ntimeout = Ntimeout;
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    hold_v_d   = hold_v_q;
    hold_tag_d = hold_tag_q;
    hold_ct_d  = hold_ct_q;
    out_v_d    = out_v_q;
    out_tag_d  = out_tag_q;
    out_ct_d   = out_ct_q;

    if (out_v_q && tag_ct_out_a) begin
      out_v_d   = 1'b0;
      out_tag_d = '0;
      out_ct_d  = '0;
    end

    if (w_accept && (tag_ct_in_ct != '0)) begin
      if (!hold_v_q) begin
        hold_v_d   = 1'b1;
        hold_tag_d = tag_ct_in_tag;
        hold_ct_d  = tag_ct_in_ct;
      end else if (w_merge_ok) begin
        hold_ct_d  = w_sum[Nct-1:0];
      end else begin
        // Only reachable with the output register empty.
        out_v_d    = 1'b1;
        out_tag_d  = hold_tag_q;
        out_ct_d   = hold_ct_q;
        hold_tag_d = tag_ct_in_tag;
        hold_ct_d  = tag_ct_in_ct;
      end
    end else if (w_flush) begin
      out_v_d    = 1'b1;
      out_tag_d  = hold_tag_q;
      out_ct_d   = hold_ct_q;
      hold_v_d   = 1'b0;
      hold_tag_d = '0;
      hold_ct_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v_q   <= 1'b0;
      hold_tag_q <= '0;
      hold_ct_q  <= '0;
      out_v_q    <= 1'b0;
      out_tag_q  <= '0;
      out_ct_q   <= '0;
    end else begin
      hold_v_q   <= hold_v_d;
      hold_tag_q <= hold_tag_d;
      hold_ct_q  <= hold_ct_d;
      out_v_q    <= out_v_d;
      out_tag_q  <= out_tag_d;
      out_ct_q   <= out_ct_d;
    end
  end

  assign tag_ct_out_v   = out_v_q;
  assign tag_ct_out_tag = out_tag_q;
  assign tag_ct_out_ct  = out_ct_q;

endmodule

`default_nettype wire
